// File: rtl/alu_operand_stage_pkg.sv
// -----------------------------------------------------------------------------
// alu_operand_stage_pkg
//   Shared definitions for the ALU operand stage:
//     - RV32I opcode constants for the four decoded major opcodes
//     - funct7 values that select SUB / SRA
//     - alu_bundle_t : the operand bundle handed to the ALU
//     - fwd_meta_t   : source-register bookkeeping used by write-back
//                      forwarding (only stored when ALU_OPFWD_EN is defined)
//     - apply_fwd()  : replaces register operands with write-back data
// -----------------------------------------------------------------------------
package alu_operand_stage_pkg;

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

    localparam logic [6:0] FUNCT7_SUB = 7'b0100000;
    localparam logic [6:0] FUNCT7_SRA = 7'b0100000;

    typedef struct packed {
        logic [31:0] in1;
        logic [31:0] in2;
        logic        is_imm;
        logic [2:0]  funct3;
        logic [6:0]  funct7;
        logic [31:0] pc;
        logic [4:0]  rd;
        logic        rd_we;
        logic        illegal;
    } alu_bundle_t;

    // use_rs1/use_rs2 are set only when the operand really is a register
    // value, so immediates, LUI/AUIPC in1 and illegal entries never forward.
    typedef struct packed {
        logic [4:0] rs1;
        logic [4:0] rs2;
        logic       use_rs1;
        logic       use_rs2;
    } fwd_meta_t;

    function automatic alu_bundle_t apply_fwd(
        input alu_bundle_t b,
        input fwd_meta_t   m,
        input logic        wb_valid,
        input logic [4:0]  wb_rd,
        input logic [31:0] wb_data
    );
        alu_bundle_t r;
        r = b;
        if (wb_valid && (wb_rd != 5'd0)) begin
            if (m.use_rs1 && (m.rs1 == wb_rd)) r.in1 = wb_data;
            if (m.use_rs2 && (m.rs2 == wb_rd)) r.in2 = wb_data;
        end
        return r;
    endfunction

endpackage

// File: rtl/alu_op_decode.sv
// -----------------------------------------------------------------------------
// alu_op_decode
//   Purely combinational decode of one RV32I instruction into the ALU operand
//   bundle. Handles OP, OP-IMM, LUI and AUIPC; everything else is flagged
//   illegal. Illegal entries carry zeroed operands/functs and rd_we=0, but
//   still report pc and rd.
//
// Ports
//   instr_i   [31:0]  instruction word
//   pc_i      [31:0]  instruction address (AUIPC operand 1)
//   rs1_i     [31:0]  register-file value of instr[19:15]
//   rs2_i     [31:0]  register-file value of instr[24:20]
//   bundle_o          decoded alu_bundle_t
//   meta_o            source indices + "operand is a register" flags
// -----------------------------------------------------------------------------
module alu_op_decode
    import alu_operand_stage_pkg::*;
(
    input  logic [31:0] instr_i,
    input  logic [31:0] pc_i,
    input  logic [31:0] rs1_i,
    input  logic [31:0] rs2_i,
    output alu_bundle_t bundle_o,
    output fwd_meta_t   meta_o
);

    logic [6:0] opcode;
    logic [2:0] f3;
    logic [6:0] f7;
    logic       illegal;

    assign opcode = instr_i[6:0];
    assign f3     = instr_i[14:12];
    assign f7     = instr_i[31:25];

    always_comb begin
        // NOTE: every output gets a default before the case so no path can
        // leave a value unassigned and infer a latch.
        bundle_o     = '0;
        meta_o       = '0;
        illegal      = 1'b0;
        bundle_o.pc  = pc_i;
        bundle_o.rd  = instr_i[11:7];
        meta_o.rs1   = instr_i[19:15];
        meta_o.rs2   = instr_i[24:20];

        case (opcode)
            OPC_OP: begin
                bundle_o.in1    = rs1_i;
                bundle_o.in2    = rs2_i;
                bundle_o.funct3 = f3;
                bundle_o.funct7 = f7;
                meta_o.use_rs1  = 1'b1;
                meta_o.use_rs2  = 1'b1;
                // The alternate funct7 only exists for SUB (000) and SRA (101).
                if (f7 == FUNCT7_SUB) illegal = !((f3 == 3'b000) || (f3 == 3'b101));
                else                  illegal = (f7 != 7'h00);
            end
            OPC_OPIMM: begin
                bundle_o.in1    = rs1_i;
                bundle_o.in2    = {{20{instr_i[31]}}, instr_i[31:20]};
                bundle_o.is_imm = 1'b1;
                bundle_o.funct3 = f3;
                meta_o.use_rs1  = 1'b1;
                // Shifts reuse imm[11:5] as funct7; other ops treat it as
                // part of the immediate.
                if (f3 == 3'b001) begin
                    bundle_o.funct7 = f7;
                    illegal         = (f7 != 7'h00);
                end else if (f3 == 3'b101) begin
                    bundle_o.funct7 = f7;
                    illegal         = !((f7 == 7'h00) || (f7 == FUNCT7_SRA));
                end
            end
            OPC_LUI: begin
                bundle_o.in2    = {instr_i[31:12], 12'b0};
                bundle_o.is_imm = 1'b1;
            end
            OPC_AUIPC: begin
                bundle_o.in1    = pc_i;
                bundle_o.in2    = {instr_i[31:12], 12'b0};
                bundle_o.is_imm = 1'b1;
            end
            default: illegal = 1'b1;
        endcase

        if (illegal) begin
            bundle_o.in1    = '0;
            bundle_o.in2    = '0;
            bundle_o.is_imm = 1'b0;
            bundle_o.funct3 = '0;
            bundle_o.funct7 = '0;
            meta_o.use_rs1  = 1'b0;
            meta_o.use_rs2  = 1'b0;
        end
        bundle_o.illegal = illegal;
        bundle_o.rd_we   = !illegal && (instr_i[11:7] != 5'd0);
    end

endmodule

// File: rtl/alu_operand_stage.sv
// -----------------------------------------------------------------------------
// alu_operand_stage
//   Pipeline stage in front of the ALU. Decodes one instruction per cycle,
//   registers the operand bundle and presents it downstream. A skid entry
//   behind the output register keeps full throughput under backpressure;
//   in_ready is registered (= skid entry empty), out_valid is registered.
//
// Configuration
//   ALU_OPFWD_EN  defined   : write-back forwarding into the captured entry
//                             and into both held entries, every cycle.
//                 undefined : wb_* inputs are ignored, no index storage.
//
// Ports
//   clk, rst                 clock, synchronous active-high reset
//   in_valid/in_ready        upstream handshake
//   in_instr, in_pc          instruction word and address
//   in_rs1_val, in_rs2_val   register-file read values
//   out_valid/out_ready      downstream handshake
//   out_in1, out_in2         ALU operands
//   out_is_imm               in2 is an immediate
//   out_funct3, out_funct7   ALU operation select / modifier
//   out_pc, out_rd, out_rd_we, out_illegal
//   wb_valid, wb_rd, wb_data write-back port (forwarding source)
//
// XLEN is fixed at 32; the decoder is RV32I only.
// -----------------------------------------------------------------------------
module alu_operand_stage
    import alu_operand_stage_pkg::*;
#(
    parameter int               XLEN     = 32,
    parameter logic [XLEN-1:0]  RESET_PC = '0
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     in_instr,
    input  logic [XLEN-1:0] in_pc,
    input  logic [XLEN-1:0] in_rs1_val,
    input  logic [XLEN-1:0] in_rs2_val,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_in1,
    output logic [XLEN-1:0] out_in2,
    output logic            out_is_imm,
    output logic [2:0]      out_funct3,
    output logic [6:0]      out_funct7,
    output logic [XLEN-1:0] out_pc,
    output logic [4:0]      out_rd,
    output logic            out_rd_we,
    output logic            out_illegal,
    input  logic            wb_valid,
    input  logic [4:0]      wb_rd,
    input  logic [XLEN-1:0] wb_data
);

    alu_bundle_t dec_b, cap_b, out_hold, skid_hold;
    alu_bundle_t out_q, out_d, skid_q, skid_d;
    fwd_meta_t   dec_meta;
    logic        out_valid_q, out_valid_d, skid_valid_q, skid_valid_d;
    logic        in_fire;

    alu_op_decode u_decode (
        .instr_i  (in_instr),
        .pc_i     (in_pc),
        .rs1_i    (in_rs1_val),
        .rs2_i    (in_rs2_val),
        .bundle_o (dec_b),
        .meta_o   (dec_meta)
    );

`ifdef ALU_OPFWD_EN
    fwd_meta_t out_meta_q, out_meta_d, skid_meta_q, skid_meta_d;

    assign cap_b     = apply_fwd(dec_b,  dec_meta,    wb_valid, wb_rd, wb_data);
    assign out_hold  = apply_fwd(out_q,  out_meta_q,  wb_valid, wb_rd, wb_data);
    assign skid_hold = apply_fwd(skid_q, skid_meta_q, wb_valid, wb_rd, wb_data);
`else
    logic unused_fwd;

    assign cap_b      = dec_b;
    assign out_hold   = out_q;
    assign skid_hold  = skid_q;
    assign unused_fwd = ^{dec_meta, wb_valid, wb_rd, wb_data};
`endif

    assign in_fire = in_valid && in_ready;

    always_comb begin
        out_d        = out_hold;
        out_valid_d  = out_valid_q;
        skid_d       = skid_hold;
        skid_valid_d = skid_valid_q;
`ifdef ALU_OPFWD_EN
        out_meta_d   = out_meta_q;
        skid_meta_d  = skid_meta_q;
`endif
        if (!out_valid_q || out_ready) begin
            // Output register frees up this cycle. in_ready is low whenever
            // the skid entry is full, so a skid refill and a new capture can
            // never coincide.
            if (skid_valid_q) begin
                out_d        = skid_hold;
                out_valid_d  = 1'b1;
                skid_valid_d = 1'b0;
`ifdef ALU_OPFWD_EN
                out_meta_d   = skid_meta_q;
`endif
            end else if (in_fire) begin
                out_d       = cap_b;
                out_valid_d = 1'b1;
`ifdef ALU_OPFWD_EN
                out_meta_d  = dec_meta;
`endif
            end else begin
                out_valid_d = 1'b0;
            end
        end else if (in_fire) begin
            skid_d       = cap_b;
            skid_valid_d = 1'b1;
`ifdef ALU_OPFWD_EN
            skid_meta_d  = dec_meta;
`endif
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: state updates use non-blocking assignments so every register
        // samples the pre-edge values regardless of statement order.
        if (rst) begin
            // NOTE: the data registers are reset as well, not just the valid
            // bits, so out_* read as zeros (pc as RESET_PC) after reset.
            out_valid_q  <= 1'b0;
            skid_valid_q <= 1'b0;
            out_q        <= '0;
            out_q.pc     <= RESET_PC;
            skid_q       <= '0;
`ifdef ALU_OPFWD_EN
            out_meta_q   <= '0;
            skid_meta_q  <= '0;
`endif
        end else begin
            out_valid_q  <= out_valid_d;
            skid_valid_q <= skid_valid_d;
            out_q        <= out_d;
            skid_q       <= skid_d;
`ifdef ALU_OPFWD_EN
            out_meta_q   <= out_meta_d;
            skid_meta_q  <= skid_meta_d;
`endif
        end
    end

    assign in_ready    = !skid_valid_q;
    assign out_valid   = out_valid_q;
    assign out_in1     = out_q.in1;
    assign out_in2     = out_q.in2;
    assign out_is_imm  = out_q.is_imm;
    assign out_funct3  = out_q.funct3;
    assign out_funct7  = out_q.funct7;
    assign out_pc      = out_q.pc;
    assign out_rd      = out_q.rd;
    assign out_rd_we   = out_q.rd_we;
    assign out_illegal = out_q.illegal;

endmodule

// File: tb/tb_alu_operand_stage.sv
// -----------------------------------------------------------------------------
// tb_alu_operand_stage
//   Self-checking bench. The reference is a queue of expected bundles (at most
//   two held entries), each computed from the instruction encoding rules when
//   the bench sees an input transfer. Every cycle the DUT's out_valid/in_ready
//   are compared against the queue occupancy and the visible bundle against
//   the queue head. Directed steps cover the documented cases; a random phase
//   follows. Forwarding expectations are applied to the queue only when
//   ALU_OPFWD_EN is defined.
// -----------------------------------------------------------------------------
module tb_alu_operand_stage;

    localparam logic [31:0] RESET_PC = 32'h0;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid, in_ready;
    logic [31:0] in_instr, in_pc, in_rs1_val, in_rs2_val;
    logic        out_valid, out_ready;
    logic [31:0] out_in1, out_in2, out_pc;
    logic        out_is_imm, out_rd_we, out_illegal;
    logic [2:0]  out_funct3;
    logic [6:0]  out_funct7;
    logic [4:0]  out_rd;
    logic        wb_valid;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;

    always #5 clk = ~clk;

    alu_operand_stage #(.XLEN(32), .RESET_PC(RESET_PC)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr), .in_pc(in_pc),
        .in_rs1_val(in_rs1_val), .in_rs2_val(in_rs2_val),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_in1(out_in1), .out_in2(out_in2), .out_is_imm(out_is_imm),
        .out_funct3(out_funct3), .out_funct7(out_funct7), .out_pc(out_pc),
        .out_rd(out_rd), .out_rd_we(out_rd_we), .out_illegal(out_illegal),
        .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data)
    );

    typedef struct {
        logic [31:0] in1, in2, pc;
        logic        is_imm, rd_we, ill, u1, u2;
        logic [2:0]  f3;
        logic [6:0]  f7;
        logic [4:0]  rd, rs1, rs2;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Expected bundle straight from the encoding rules.
    function automatic exp_t model(input logic [31:0] ins, input logic [31:0] pc,
                                   input logic [31:0] r1, input logic [31:0] r2);
        exp_t       e;
        logic [6:0] op;
        logic [2:0] f3;
        logic [6:0] f7;
        op = ins[6:0];
        f3 = ins[14:12];
        f7 = ins[31:25];
        e = '{default: 0};
        e.pc  = pc;
        e.rd  = ins[11:7];
        e.rs1 = ins[19:15];
        e.rs2 = ins[24:20];
        e.ill = 1'b1;
        case (op)
            7'h33: begin
                e.ill = !((f7 == 7'h00) || (f7 == 7'h20 && (f3 == 3'd0 || f3 == 3'd5)));
                e.in1 = r1; e.in2 = r2; e.f3 = f3; e.f7 = f7; e.u1 = 1'b1; e.u2 = 1'b1;
            end
            7'h13: begin
                e.ill = (f3 == 3'd1 && f7 != 7'h00) ||
                        (f3 == 3'd5 && !(f7 == 7'h00 || f7 == 7'h20));
                e.in1 = r1; e.in2 = {{20{ins[31]}}, ins[31:20]}; e.is_imm = 1'b1;
                e.f3 = f3; e.f7 = (f3 == 3'd1 || f3 == 3'd5) ? f7 : 7'h00; e.u1 = 1'b1;
            end
            7'h37: begin
                e.ill = 1'b0; e.in2 = ins & 32'hFFFF_F000; e.is_imm = 1'b1;
            end
            7'h17: begin
                e.ill = 1'b0; e.in1 = pc; e.in2 = ins & 32'hFFFF_F000; e.is_imm = 1'b1;
            end
            default: ;
        endcase
        if (e.ill) begin
            e.in1 = 0; e.in2 = 0; e.f3 = 0; e.f7 = 0; e.u1 = 0; e.u2 = 0;
        end
        e.rd_we = !e.ill && (e.rd != 5'd0);
        return e;
    endfunction

    task automatic compare(input exp_t e);
        check("in1", out_in1, e.in1);
        check("in2", out_in2, e.in2);
        check("funct3", out_funct3, e.f3);
        check("funct7", out_funct7, e.f7);
        check("pc", out_pc, e.pc);
        check("rd", out_rd, e.rd);
        check("rd_we", out_rd_we, e.rd_we);
        check("illegal", out_illegal, e.ill);
        if (!e.ill) check("is_imm", out_is_imm, e.is_imm);
    endtask

    // One clock: check against the model on the falling edge, advance the
    // model by the transfers that the coming rising edge will perform, then
    // return 1 time unit after that edge with the new DUT state visible.
    task automatic cycle();
        @(negedge clk);
        check("out_valid_vs_model", out_valid, q.size() != 0);
        check("in_ready_vs_model", in_ready, q.size() < 2);
        if (out_valid && q.size() != 0) compare(q[0]);
        if (rst) begin
            q.delete();
        end else begin
            if (out_valid && out_ready && q.size() != 0) void'(q.pop_front());
            if (in_valid && in_ready) q.push_back(model(in_instr, in_pc, in_rs1_val, in_rs2_val));
`ifdef ALU_OPFWD_EN
            if (wb_valid && wb_rd != 5'd0) begin
                foreach (q[i]) begin
                    exp_t t;
                    t = q[i];
                    if (t.u1 && t.rs1 == wb_rd) t.in1 = wb_data;
                    if (t.u2 && t.rs2 == wb_rd) t.in2 = wb_data;
                    q[i] = t;
                end
            end
`endif
        end
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] rand_instr();
        logic [31:0] ins;
        logic [6:0]  f7s [3];
        ins    = $urandom;
        f7s[0] = 7'h00;
        f7s[1] = 7'h20;
        f7s[2] = 7'($urandom);
        case ($urandom_range(0, 5))
            0, 1: begin ins[6:0] = 7'h33; ins[31:25] = f7s[$urandom_range(0, 2)]; end
            2:    begin ins[6:0] = 7'h13; if ($urandom_range(0, 1) == 1) ins[31:25] = f7s[$urandom_range(0, 2)]; end
            3:    ins[6:0] = 7'h37;
            4:    ins[6:0] = 7'h17;
            default: ;
        endcase
        return ins;
    endfunction

    initial begin
        rst = 1'b1; in_valid = 1'b0; in_instr = '0; in_pc = '0;
        in_rs1_val = '0; in_rs2_val = '0; out_ready = 1'b0;
        wb_valid = 1'b0; wb_rd = '0; wb_data = '0;
        @(posedge clk); @(posedge clk); #1;

        // Reset state
        check("rst_out_valid", out_valid, 0);
        check("rst_in_ready", in_ready, 1);
        check("rst_in1", out_in1, 0);
        check("rst_in2", out_in2, 0);
        check("rst_pc", out_pc, RESET_PC);
        check("rst_rd_we", out_rd_we, 0);
        check("rst_illegal", out_illegal, 0);
        rst = 1'b0;

        // 1: ADD x3,x1,x2 with one-cycle latency
        in_valid = 1'b1; in_instr = 32'h002081B3; in_pc = 32'h40;
        in_rs1_val = 32'd5; in_rs2_val = 32'd7; out_ready = 1'b1;
        cycle();
        in_valid = 1'b0;
        check("add_valid", out_valid, 1);
        check("add_in1", out_in1, 5);
        check("add_in2", out_in2, 7);
        check("add_funct3", out_funct3, 0);
        check("add_funct7", out_funct7, 0);
        check("add_is_imm", out_is_imm, 0);
        check("add_rd", out_rd, 3);
        check("add_rd_we", out_rd_we, 1);

        // 2: SRAI, then SLLI with funct7=0x20 (illegal)
        in_valid = 1'b1; in_instr = 32'h4040D093; in_rs1_val = 32'h8000_0000;
        cycle();
        check("srai_is_imm", out_is_imm, 1);
        check("srai_in2", out_in2, 32'h404);
        check("srai_funct3", out_funct3, 3'b101);
        check("srai_funct7", out_funct7, 7'h20);
        check("srai_illegal", out_illegal, 0);
        in_instr = 32'h40009093;
        cycle();
        in_valid = 1'b0;
        check("slli_illegal", out_illegal, 1);
        check("slli_rd_we", out_rd_we, 0);
        check("slli_in1", out_in1, 0);

        // 3: AUIPC x5,0x12345 at pc 0x100
        in_valid = 1'b1; in_instr = 32'h12345297; in_pc = 32'h100;
        cycle();
        in_valid = 1'b0;
        check("auipc_in1", out_in1, 32'h100);
        check("auipc_in2", out_in2, 32'h1234_5000);
        check("auipc_funct3", out_funct3, 0);
        check("auipc_is_imm", out_is_imm, 1);
        cycle();

        // 4: three back-to-back ADDIs under 3 cycles of backpressure
        out_ready = 1'b0; in_valid = 1'b1; in_instr = 32'h00108193;
        cycle();
        check("bp_ready_1", in_ready, 1);
        in_instr = 32'h00208193;
        cycle();
        check("bp_ready_2", in_ready, 0);
        check("bp_head_1", out_in2, 1);
        in_instr = 32'h00308193;
        cycle();
        check("bp_ready_3", in_ready, 0);
        check("bp_hold_1", out_in2, 1);
        out_ready = 1'b1;
        cycle();
        check("bp_head_2", out_in2, 2);
        check("bp_ready_4", in_ready, 1);
        cycle();
        check("bp_head_3", out_in2, 3);
        in_valid = 1'b0;
        cycle();
        check("bp_drained", out_valid, 0);

        // 5: reset with two entries held
        out_ready = 1'b0; in_valid = 1'b1; in_instr = 32'h00108193;
        cycle();
        in_instr = 32'h00208193;
        cycle();
        in_valid = 1'b0; rst = 1'b1;
        cycle();
        check("rst2_out_valid", out_valid, 0);
        check("rst2_in_ready", in_ready, 1);
        check("rst2_in1", out_in1, 0);
        check("rst2_in2", out_in2, 0);
        check("rst2_funct3", out_funct3, 0);
        check("rst2_pc", out_pc, RESET_PC);
        check("rst2_rd", out_rd, 0);
        rst = 1'b0; out_ready = 1'b1;

`ifdef ALU_OPFWD_EN
        // 6: forwarding into held entries
        out_ready = 1'b0; in_valid = 1'b1; in_instr = 32'h002081B3;
        in_rs1_val = 32'd5; in_rs2_val = 32'd7;
        cycle();
        in_valid = 1'b0; wb_valid = 1'b1; wb_rd = 5'd1; wb_data = 32'hDEAD;
        cycle();
        check("fwd_in1", out_in1, 32'hDEAD);
        wb_rd = 5'd0; wb_data = 32'hBEEF;
        cycle();
        check("fwd_x0_in1", out_in1, 32'hDEAD);
        wb_valid = 1'b0; in_valid = 1'b1; in_instr = 32'h01208193; in_rs1_val = 32'd9;
        cycle();
        in_valid = 1'b0; wb_valid = 1'b1; wb_rd = 5'd2; wb_data = 32'h5555;
        cycle();
        wb_valid = 1'b0; out_ready = 1'b1;
        cycle();
        check("fwd_imm_in2", out_in2, 32'h12);
        check("fwd_imm_in1", out_in1, 9);
        cycle();
`endif

        // Random phase (wb_* driven too: ignored unless forwarding is built in)
        for (int i = 0; i < 400; i++) begin
            in_valid   = 1'($urandom_range(0, 1));
            out_ready  = ($urandom_range(0, 3) != 0);
            in_instr   = rand_instr();
            in_pc      = $urandom;
            in_rs1_val = $urandom;
            in_rs2_val = $urandom;
            wb_valid   = 1'($urandom_range(0, 1));
            wb_rd      = 5'($urandom_range(0, 4));
            wb_data    = $urandom;
            rst        = ($urandom_range(0, 99) == 0);
            cycle();
        end

        rst = 1'b0; in_valid = 1'b0; out_ready = 1'b1; wb_valid = 1'b0;
        repeat (3) cycle();
        check("drain_empty", out_valid, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
